// File: rtl/div_sequencer.sv
// div_sequencer: sits between the execute stage and the shared iterative
// divider. Handles divide-by-zero and signed overflow locally, serves repeated
// operand pairs from a one-entry result cache, and otherwise runs the divider
// and stalls execute until the result comes back.
module div_sequencer #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  input  logic [1:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_dividend,
  input  logic [DATA_WIDTH-1:0] req_divisor,
  input  logic                  flush,
  output logic                  stall,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_result,
  output logic                  div_start,
  output logic [DATA_WIDTH-1:0] div_dividend,
  output logic [DATA_WIDTH-1:0] div_divisor,
  output logic                  div_unsigned,
  input  logic [DATA_WIDTH-1:0] div_quotient,
  input  logic [DATA_WIDTH-1:0] div_remainder,
  input  logic                  div_done
);

  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DRAIN,
    RESP
  } state_t;

  state_t state;
  state_t state_nx;

  // Selects remainder (1) or quotient (0) for the accepted request.
  logic                  rem_sel_q;

  logic                  cache_valid;
  logic [DATA_WIDTH-1:0] cache_dividend;
  logic [DATA_WIDTH-1:0] cache_divisor;
  logic                  cache_unsigned;
  logic [DATA_WIDTH-1:0] cache_quotient;
  logic [DATA_WIDTH-1:0] cache_remainder;

  logic                  div_by_zero;
  logic                  sgn_overflow;
  logic                  cache_hit;
  logic                  fast_path;
  logic [DATA_WIDTH-1:0] fast_result;

  logic                  accept;
  logic                  done_ok;
  logic                  cache_wr;

  // Classify the incoming request and form the result for the 1-cycle path.
  always_comb begin
    div_by_zero  = (req_divisor == '0);
    sgn_overflow = !req_op[0] && (req_dividend == MIN_NEG) && (req_divisor == '1);
    cache_hit    = cache_valid
                && (cache_dividend == req_dividend)
                && (cache_divisor == req_divisor)
                && (cache_unsigned == req_op[0]);
    fast_path    = div_by_zero || sgn_overflow || cache_hit;
    fast_result  = '0;
    if (div_by_zero) begin
      fast_result = req_op[1] ? req_dividend : '1;
    end else if (sgn_overflow) begin
      fast_result = req_op[1] ? '0 : MIN_NEG;
    end else begin
      fast_result = req_op[1] ? cache_remainder : cache_quotient;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    done_ok    = 1'b0;
    cache_wr   = 1'b0;
    resp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid && !flush) begin
          accept   = 1'b1;
          state_nx = fast_path ? RESP : BUSY;
        end
      end
      BUSY: begin
        // div_done is not trusted in the cycle that carries div_start.
        done_ok = div_done && !div_start;
        if (done_ok && flush) begin
          state_nx = IDLE;
        end else if (done_ok) begin
          cache_wr = 1'b1;
          state_nx = RESP;
        end else if (flush) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (div_done) begin
          state_nx = IDLE;
        end
      end
      RESP: begin
        resp_valid = !flush;
        state_nx   = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign stall = req_valid && !resp_valid;

  // Divider interface registers: operands latched on accept, one-cycle start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_start    <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      div_unsigned <= 1'b0;
      rem_sel_q    <= 1'b0;
    end else begin
      div_start <= accept && !fast_path;
      if (accept) begin
        div_dividend <= req_dividend;
        div_divisor  <= req_divisor;
        div_unsigned <= req_op[0];
        rem_sel_q    <= req_op[1];
      end
    end
  end

  // Result register: loaded from the fast path or the divider, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_result <= '0;
    end else if (accept && fast_path) begin
      resp_result <= fast_result;
    end else if (cache_wr) begin
      resp_result <= rem_sel_q ? div_remainder : div_quotient;
    end
  end

  // Cache valid bit; only a completed, unflushed divide sets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache_valid <= 1'b0;
    end else if (cache_wr) begin
      cache_valid <= 1'b1;
    end
  end

  // Cache payload; meaningless while cache_valid is low, so it has no reset.
  always_ff @(posedge clk) begin
    if (cache_wr) begin
      cache_dividend  <= div_dividend;
      cache_divisor   <= div_divisor;
      cache_unsigned  <= div_unsigned;
      cache_quotient  <= div_quotient;
      cache_remainder <= div_remainder;
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: drives divide requests into div_sequencer with a
// behavioural divider of programmable latency; expected results are queued
// at request time and checked when resp_valid appears.
module tb_div_sequencer;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_dividend;
  logic [31:0] req_divisor;
  logic        flush;
  logic        stall;
  logic        resp_valid;
  logic [31:0] resp_result;
  logic        div_start;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_unsigned;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic        div_done;

  int          n_cmp;
  int          n_err;
  int          lat;
  logic [31:0] sb_q[$];

  div_sequencer #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .flush        (flush),
    .stall        (stall),
    .resp_valid   (resp_valid),
    .resp_result  (resp_result),
    .div_start    (div_start),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_unsigned (div_unsigned),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder),
    .div_done     (div_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // {quotient, remainder} as RISC-V defines them.
  function automatic logic [63:0] model_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic u);
    int sa;
    int sb;
    if (b == 32'h0) return {32'hFFFF_FFFF, a};
    if (u) return {a / b, a % b};
    sa = $signed(a);
    sb = $signed(b);
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    return {32'(sa / sb), 32'(sa % sb)};
  endfunction

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] qr;
    qr = model_div(a, b, op[0]);
    return op[1] ? qr[31:0] : qr[63:32];
  endfunction

  // Behavioural divider: div_done for one cycle, lat cycles after div_start.
  int unsigned m_cnt;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic        m_u;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0;
      div_done      <= 1'b0;
      div_quotient  <= '0;
      div_remainder <= '0;
    end else begin
      div_done <= 1'b0;
      if (div_start) begin
        m_cnt = lat;
        m_a   = div_dividend;
        m_b   = div_divisor;
        m_u   = div_unsigned;
      end
      if (m_cnt > 0) begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          div_done <= 1'b1;
          {div_quotient, div_remainder} <= model_div(m_a, m_b, m_u);
        end
      end
    end
  end

  // Scoreboard consumer.
  always @(negedge clk) begin
    if (rst_n && resp_valid) begin
      if (sb_q.size() == 0) check_val("unexp_resp", 32'd1, 32'd0);
      else check_val("result", resp_result, sb_q.pop_front());
    end
  end

  // Waits for the response of the request currently on req_*; n counts
  // negedges from the cycle the request is first seen by an IDLE sequencer.
  task automatic wait_resp(input int exp_start_n, input int exp_resp_n);
    int n;
    int starts;
    bit got;
    bit stall_bad;
    n = 0; starts = 0; got = 0; stall_bad = 0;
    while (!got && n < 100) begin
      @(negedge clk);
      if (div_start) begin
        starts++;
        check_val("start_cycle", n, exp_start_n);
        check_val("start_dvd", div_dividend, req_dividend);
        check_val("start_dvs", div_divisor, req_divisor);
        check_val("start_uns", {31'b0, div_unsigned}, {31'b0, req_op[0]});
      end
      if (resp_valid) begin
        got = 1;
        check_val("latency", n, exp_resp_n);
        check_val("stall_resp", {31'b0, stall}, 32'd0);
      end else if (!stall) begin
        stall_bad = 1;
      end
      n++;
    end
    check_val("resp_seen", {31'b0, got}, 32'd1);
    check_val("stall_hold", {31'b0, stall_bad}, 32'd0);
    check_val("start_count", starts, (exp_start_n >= 0) ? 32'd1 : 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit exp_div, input int l);
    lat          = l;
    req_op       = op;
    req_dividend = a;
    req_divisor  = b;
    req_valid    = 1'b1;
    sb_q.push_back(ref_div(op, a, b));
    if (exp_div) wait_resp(1, l + 2);
    else wait_resp(-1, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; lat = 4;
    rst_n = 1'b0; req_valid = 1'b0; req_op = 2'b00;
    req_dividend = '0; req_divisor = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst0_ctrl", {28'b0, resp_valid, div_start, div_unsigned, stall}, 32'd0);
    check_val("rst0_result", resp_result, 32'd0);
    check_val("rst0_ops", div_dividend | div_divisor, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Divider path, cache hit, signedness miss.
    do_req(OP_DIVU, 32'd100, 32'd7, 1, 4);
    do_req(OP_REMU, 32'd100, 32'd7, 0, 4);
    do_req(OP_REM,  32'd100, 32'd7, 1, 2);
    // Signed overflow, then the same operands unsigned.
    do_req(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 2);
    do_req(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0, 2);
    do_req(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1);
    // Divide by zero.
    do_req(OP_DIVU, 32'd5, 32'd0, 0, 2);
    do_req(OP_REMU, 32'd5, 32'd0, 0, 2);
    do_req(OP_DIV,  32'hFFFF_FFF9, 32'd0, 0, 2);
    // Negative signed operands and a signed cache hit.
    do_req(OP_DIV,  32'hFFFF_FFF9, 32'd2, 1, 3);
    do_req(OP_REM,  32'hFFFF_FFF9, 32'd2, 0, 3);

    // Flush two cycles after div_start: drain, no result, no cache write.
    lat = 6;
    req_op = OP_DIV; req_dividend = 32'd1000; req_divisor = 32'd10; req_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("fl_start", {31'b0, div_start}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    req_op = OP_REM;
    sb_q.push_back(ref_div(OP_REM, 32'd1000, 32'd10));
    // Divider finishes 4 cycles after the flush; the new request waits in DRAIN.
    wait_resp(5, 12);

    // Flush coincident with div_done: straight back to IDLE, no cache write.
    lat = 3;
    req_op = OP_DIVU; req_dividend = 32'd77; req_divisor = 32'd5; req_valid = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check_val("coinc_idle", {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    do_req(OP_REMU, 32'd77, 32'd5, 1, 3);

    // Asynchronous reset in the middle of a divide.
    do_req(OP_DIVU, 32'd12345, 32'd67, 1, 5);
    lat = 5;
    req_op = OP_DIV; req_dividend = 32'd999; req_divisor = 32'd3; req_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("arst_ctrl", {28'b0, resp_valid, div_start, div_unsigned, stall}, 32'd0);
    check_val("arst_result", resp_result, 32'd0);
    check_val("arst_dvd", div_dividend, 32'd0);
    check_val("arst_dvs", div_divisor, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(OP_REMU, 32'd12345, 32'd67, 1, 3);

    repeat (3) @(posedge clk);
    check_val("sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Controller between the execute stage and the shared iterative divider. It accepts DIV/DIVU/REM/REMU requests from execute, resolves divide-by-zero and signed overflow without using the divider, and reuses a one-entry result cache so a DIV/REM pair on the same operands starts the divider only once. It drives the divider's start/operand interface and generates the execute-stage stall.

## Interface
- DATA_WIDTH, 32, operand/result width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  divide request present in execute; operands held stable while stall=1
- req_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- req_dividend  in  DATA_WIDTH  rs1 operand
- req_divisor  in  DATA_WIDTH  rs2 operand
- flush  in  1  kill the current request (branch/trap redirect)
- stall  out  1  hold the pipeline; = req_valid && !resp_valid
- resp_valid  out  1  one-cycle result strobe
- resp_result  out  DATA_WIDTH  result, valid when resp_valid=1
- div_start  out  1  one-cycle start pulse to the divider
- div_dividend  out  DATA_WIDTH  registered dividend to the divider
- div_divisor  out  DATA_WIDTH  registered divisor to the divider
- div_unsigned  out  1  registered signedness (req_op[0])
- div_quotient  in  DATA_WIDTH  divider quotient
- div_remainder  in  DATA_WIDTH  divider remainder
- div_done  in  1  divider result valid; at least one cycle after div_start

## Operation
- States: IDLE, BUSY, DRAIN, RESP. Reset: IDLE, all outputs 0, cache_valid=0.
- IDLE, req_valid=1, flush=0: accept; latch op and operands.
  - divisor==0: result = all-ones (DIV/DIVU), dividend (REM/REMU); go RESP.
  - signed op, dividend==0x8000_0000, divisor==0xFFFF_FFFF: result = 0x8000_0000 (DIV), 0 (REM); go RESP.
  - cache hit (cache_valid, dividends, divisors and unsigned flag all equal): result = cached quotient (op[1]=0) or remainder (op[1]=1); go RESP.
  - otherwise: go BUSY.
  - Priority: divide-by-zero, overflow, cache hit, divider.
- IDLE with flush=1 or req_valid=0: stay IDLE.
- BUSY: div_start=1 in the first BUSY cycle only. div_dividend/div_divisor/div_unsigned stay stable through BUSY and DRAIN. div_done is ignored in the div_start cycle.
  - On div_done: write the cache (operands, flag, quotient, remainder, valid=1); select the result by op[1]; go RESP.
  - flush=1 with no div_done: go DRAIN.
  - flush=1 in the same cycle as div_done: go IDLE, no cache write.
- DRAIN: the divider cannot be aborted. Wait for div_done, discard the result, no cache write, then go IDLE.
- RESP: resp_valid = !flush for exactly one cycle; next state IDLE unconditionally.
- Special-case results never write the cache. Reset clears cache_valid only; cache data is don't-care.
- resp_result holds its last value outside RESP.

## Timing
- Request accepted at the clock edge ending an IDLE cycle (cycle A).
- Fast path (special case or cache hit): resp_valid in cycle A+1. Latency 1, no div_start.
- Divider path: div_start in cycle A+1. With divider done-latency L (div_done in cycle A+1+L, L≥1), resp_valid is in cycle A+2+L.
- stall is combinational from req_valid and resp_valid. The pipeline advances at the edge ending the resp_valid cycle.
- Back-to-back requests: the next request is evaluated in the IDLE cycle after RESP. Minimum issue interval is 2 cycles.
- flush is a synchronous input. rst_n assertion forces IDLE and zeros outputs immediately, independent of clk, including mid-BUSY. The external divider is reset by the same rst_n.

## Test plan
- DIVU 100/7, bench divider L=4 -> one div_start pulse with div_dividend=100, div_divisor=7; resp_valid exactly 6 cycles after accept; resp_result=14; stall high until that cycle.
- REMU 100/7 immediately after -> no div_start, resp_result=2 one cycle after accept. Then REM 100/7 (signed, flag differs) -> div_start issued.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000 after 1 cycle, no div_start. REM with the same operands -> 0. DIVU with the same operands -> div_start issued.
- DIVU 5/0 -> 0xFFFF_FFFF; REMU 5/0 -> 5; DIV 0xFFFF_FFF9/0 -> 0xFFFF_FFFF. All 1-cycle, no div_start.
- DIV 1000/10, flush 2 cycles after div_start, L=6 -> DRAIN until div_done, no resp_valid, no cache write. A following REM 1000/10 issues div_start and returns 0. Also check flush coincident with div_done goes to IDLE.
- rst_n low mid-BUSY -> state IDLE and all outputs 0 asynchronously. After release, a repeat of the pre-reset operands misses the cache and issues div_start.
